// File: rtl/serial_adder_param.sv
// serial_adder_param
//   Digit-serial adder/subtractor. It adds or subtracts two WIDTH-bit operands
//   DIGIT bits per clock, least significant digit first, through a registered
//   carry. It reports the sum, the raw carry-out and signed overflow through a
//   start/busy/done handshake.
//
// Parameters
//   WIDTH  operand/result width (>= 1)
//   DIGIT  bits processed per clock (WIDTH % DIGIT == 0)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     operation request, sampled whenever not busy (IDLE or DONE)
//   sub       0 = a + b + cin, 1 = a - b - cin (latched on accept)
//   a, b      operands (latched on accept)
//   cin       carry-in / borrow-in (latched on accept)
//   busy      high while the operation is being stepped
//   done      one-cycle pulse, results valid
//   sum       result, held until the next operation completes
//   cout      carry out of the MSB (for subtract, 1 = no borrow)
//   overflow  signed two's-complement overflow
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start
// RUN    | stepping one digit per clock, counter runs N-1 down to 0
// DONE   | results valid for one cycle; start here goes straight to RUN

module serial_adder_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder_param: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DIGIT:0]     dig_add;
  logic [DIGIT-1:0]   dig_sum;
  logic               dig_cout;
  logic [WIDTH-1:0]   res_next;
  logic               accept;

  // One digit of the ripple, plus the result with that digit entering from the top.
  always_comb begin
    dig_add  = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
             + {{DIGIT{1'b0}}, carry_q};
    dig_sum  = dig_add[DIGIT-1:0];
    dig_cout = dig_add[DIGIT];
    res_next = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
  end

  assign accept = start && (state_q != S_RUN);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        res_d   = res_next;
        carry_d = dig_cout;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          sum_d   = res_next;
          cout_d  = dig_cout;
          // The carry into the MSB equals a^b^s at that bit, so overflow is
          // a^b^s^cout there. This form works for any DIGIT, including WIDTH=1.
          ovf_d   = a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1] ^ dig_sum[DIGIT-1] ^ dig_cout;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Subtraction is a + ~b + ~cin, so both inversions are applied at load time.
    if (accept) begin
      state_d = S_RUN;
      a_sh_d  = a;
      b_sh_d  = sub ? ~b : b;
      carry_d = sub ? ~cin : cin;
      cnt_d   = CNT_W'(N - 1);
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_param.sv
module tb_serial_adder_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1, DIGIT=1
  logic start1 = 1'b0, sub1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic busy1, done1, sum1, cout1, ovf1;
  // WIDTH=8, DIGIT=1
  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  // WIDTH=8, DIGIT=4
  logic       start84 = 1'b0, sub84 = 1'b0, cin84 = 1'b0;
  logic [7:0] a84 = '0, b84 = '0;
  logic       busy84, done84, cout84, ovf84;
  logic [7:0] sum84;

  serial_adder_param #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));

  serial_adder_param #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));

  serial_adder_param #(.WIDTH(8), .DIGIT(4)) u84 (
    .clk(clk), .rst_n(rst_n), .start(start84), .sub(sub84), .a(a84), .b(b84), .cin(cin84),
    .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .overflow(ovf84));

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] last_sum8 = 8'h00;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic sub, a, b, cin;
    logic s, c, o;
  } vec1_t;

  typedef struct {
    logic       sub;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       c, o;
  } vec8_t;

  vec1_t v1[9];
  vec8_t v8[8];

  task automatic do_op1(input vec1_t v, input string nm);
    int cyc, busyc;
    @(negedge clk);
    sub1 = v.sub; a1 = v.a; b1 = v.b; cin1 = v.cin; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 0; busyc = 0;
    while (!done1 && cyc < 20) begin
      if (busy1) busyc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'd1);
    chk({nm, " busy cycles"}, 32'(busyc), 32'd1);
    chk({nm, " sum"}, 32'(sum1), 32'(v.s));
    chk({nm, " cout"}, 32'(cout1), 32'(v.c));
    chk({nm, " ovf"}, 32'(ovf1), 32'(v.o));
    @(posedge clk); #1;
    chk({nm, " done width"}, 32'(done1), 32'd0);
  endtask

  task automatic do_op8(input vec8_t v, input string nm);
    int cyc, busyc;
    @(negedge clk);
    sub8 = v.sub; a8 = v.a; b8 = v.b; cin8 = v.cin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk({nm, " sum held in run"}, 32'(sum8), 32'(last_sum8));
    cyc = 0; busyc = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) busyc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'd8);
    chk({nm, " busy cycles"}, 32'(busyc), 32'd8);
    chk({nm, " busy at done"}, 32'(busy8), 32'd0);
    chk({nm, " sum"}, 32'(sum8), 32'(v.s));
    chk({nm, " cout"}, 32'(cout8), 32'(v.c));
    chk({nm, " ovf"}, 32'(ovf8), 32'(v.o));
    last_sum8 = v.s;
    @(posedge clk); #1;
    chk({nm, " done width"}, 32'(done8), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ndone;

    // Full-adder truth table (add), plus one 1-bit subtract: 0 - 1 - 0.
    v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    v1[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    v1[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    v1[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v1[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    v1[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    v1[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    v1[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    v8[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    v8[1] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    v8[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    v8[3] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    v8[4] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    v8[5] = '{1'b0, 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};
    v8[6] = '{1'b1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b1, 1'b0};
    v8[7] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset busy8", 32'(busy8), 32'd0);
    chk("reset done8", 32'(done8), 32'd0);
    chk("reset sum8", 32'(sum8), 32'd0);
    chk("reset cout8/ovf8", 32'({cout8, ovf8}), 32'd0);
    chk("reset u1 outputs", 32'({busy1, done1, sum1, cout1, ovf1}), 32'd0);
    chk("reset u84 outputs", 32'({busy84, done84, sum84, cout84, ovf84}), 32'd0);

    for (int i = 0; i < 9; i++) do_op1(v1[i], $sformatf("w1 v%0d", i));
    for (int i = 0; i < 8; i++) do_op8(v8[i], $sformatf("w8 v%0d", i));

    // start while busy must be ignored
    @(negedge clk);
    sub8 = 1'b0; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0; ndone = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) begin a8 = 8'hAA; start8 = 1'b1; end
      else start8 = 1'b0;
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        if (ndone == 1) begin
          cyc = k;
          chk("ignore sum", 32'(sum8), 32'h02);
        end
      end
    end
    start8 = 1'b0;
    chk("ignore latency", 32'(cyc), 32'd8);
    chk("ignore done count", 32'(ndone), 32'd1);
    chk("ignore busy after", 32'(busy8), 32'd0);
    last_sum8 = 8'h02;

    // WIDTH=8 DIGIT=4: 3C+0F, then back-to-back 10+20 via the DONE cycle
    @(negedge clk);
    sub84 = 1'b0; cin84 = 1'b0; a84 = 8'h3C; b84 = 8'h0F; start84 = 1'b1;
    @(posedge clk); #1;
    a84 = 8'h10; b84 = 8'h20;
    chk("d4 run1 busy", 32'({busy84, done84}), 32'b10);
    @(posedge clk); #1;
    chk("d4 run2 busy", 32'({busy84, done84}), 32'b10);
    chk("d4 sum held", 32'(sum84), 32'h00);
    @(posedge clk); #1;
    chk("d4 done", 32'({busy84, done84}), 32'b01);
    chk("d4 sum 4B", 32'(sum84), 32'h4B);
    chk("d4 cout/ovf", 32'({cout84, ovf84}), 32'b00);
    @(posedge clk); #1;
    start84 = 1'b0;
    chk("d4 b2b busy", 32'({busy84, done84}), 32'b10);
    chk("d4 b2b sum held", 32'(sum84), 32'h4B);
    @(posedge clk); #1;
    chk("d4 b2b run2", 32'({busy84, done84}), 32'b10);
    @(posedge clk); #1;
    chk("d4 b2b done", 32'({busy84, done84}), 32'b01);
    chk("d4 sum 30", 32'(sum84), 32'h30);
    @(posedge clk); #1;
    chk("d4 idle", 32'({busy84, done84}), 32'b00);

    // reset in the middle of FF+01
    @(negedge clk);
    sub8 = 1'b0; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst pre busy", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async busy", 32'(busy8), 32'd0);
    chk("rst async done", 32'(done8), 32'd0);
    chk("rst async sum", 32'(sum8), 32'd0);
    chk("rst async cout/ovf", 32'({cout8, ovf8}), 32'd0);
    ndone = 0;
    repeat (3) begin @(posedge clk); #1; if (done8) ndone++; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (done8 || busy8) ndone++; end
    chk("rst no done", 32'(ndone), 32'd0);
    last_sum8 = 8'h00;
    do_op8(v8[4], "after rst 12+34");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
